i2c_apb_regfile_v2: RTL and testbench
=====================================

Name: i2c_apb_regfile_v2

Overview:
- Parametrised successor of the I2C APB register block. Sits between the APB bus and the I2C core / TX-RX FIFOs.
- Adds over the previous generation:
  - configurable data width and wait states
  - a real APB FSM with PREADY wait states and PSLVERR
  - FIFO-aware push/pop with full/empty protection
  - self-clearing CMD
  - sticky W1C interrupt status with enable mask and IRQ output

Parameters:
DATA_WIDTH, 8, register/APB data width (>=8); status/irq vectors use the same width
ADDR_WIDTH, 8, APB address width; only low 3 bits decoded, upper bits must be 0 else unmapped
WAIT_STATES, 0, extra access-phase cycles inserted on every transfer (0..7)
PRESCALER_RST, 0, reset value of PRESCALER

Ports:
pclk_i  in  1  clock, all logic on rising edge
preset_i  in  1  asynchronous active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  1=write, 0=read
paddr_i  in  ADDR_WIDTH  APB address
pwdata_i  in  DATA_WIDTH  write data
prdata_o  out  DATA_WIDTH  read data, valid only while pready_o=1, else 0
pready_o  out  1  transfer complete
pslverr_o  out  1  error, valid only with pready_o
prescaler_o  out  DATA_WIDTH  PRESCALER register
cmd_o  out  DATA_WIDTH  CMD register
address_rw_o  out  DATA_WIDTH  ADDR_RW register
cmd_clr_i  in  1  core pulse: clear CMD
status_i  in  DATA_WIDTH  live core status
tx_data_o  out  DATA_WIDTH  TX FIFO write data
tx_wr_en_o  out  1  TX FIFO push, 1-cycle pulse
tx_full_i  in  1  TX FIFO full
rx_data_i  in  DATA_WIDTH  RX FIFO head, valid 1 cycle after rx_rd_en_o
rx_rd_en_o  out  1  RX FIFO pop, 1-cycle pulse
rx_empty_i  in  1  RX FIFO empty
irq_src_i  in  DATA_WIDTH  interrupt event pulses
irq_o  out  1  registered interrupt

Behaviour:
Address map:
- 0 PRESCALER RW
- 1 CMD RW
- 2 TXDATA W (read returns last written value)
- 3 RXDATA R
- 4 ADDR_RW RW
- 5 STATUS R (status_i sampled at completion)
- 6 IRQ_EN RW
- 7 IRQ_STAT R/W1C

Reset (preset_i=1, async):
- PRESCALER=PRESCALER_RST; all other registers 0.
- All outputs 0, including pready_o.
- FSM forced to IDLE.
- A transfer in flight is dropped with no side effects.

FSM states IDLE, WAIT, POP, RESP:
- IDLE: on psel_i & !penable_i, latch addr/write/wdata.
  - Compute err:
    - unmapped address
    - write to 3 or 5
    - write to 2 with tx_full_i=1
    - read of 3 with rx_empty_i=1
  - Load cnt=WAIT_STATES.
  - If read of 3 with no error: go to POP; else go to WAIT (or RESP when cnt=0).
- POP: rx_rd_en_o=1 for exactly this cycle. Next cycle capture rx_data_i, then go to WAIT/RESP.
- WAIT: decrement cnt; go to RESP when cnt reaches 0.
- RESP:
  - pready_o=1 for exactly one cycle; pslverr_o=err.
  - On a read, prdata_o=selected value (0 on err).
  - Return to IDLE.
- Timing: zero-wait transfer has pready_o high in the first access cycle. RXDATA read takes +1 cycle. WAIT_STATES adds N cycles.
- Side effects commit at the RESP edge only if err=0:
  - register write takes effect
  - TXDATA write: tx_data_o=pwdata, tx_wr_en_o pulses 1 cycle on the next cycle
- Errored writes change nothing.
- psel_i dropping before RESP (protocol abort): return to IDLE, no commit. A pop already issued is not undone.

CMD:
- cmd_clr_i=1 clears CMD.
- If an APB write to CMD commits in the same cycle, the write wins.

IRQ_STAT:
- Bit i set when irq_src_i[i]=1.
- W1C clears bits written 1.
- Set and clear in the same cycle: set wins.
- irq_o registered = |(IRQ_STAT & IRQ_EN); 1-cycle latency from the register update.

Widths: all registers are DATA_WIDTH bits; no truncation.

Test Plan:
- Reset: preset_i pulse mid-transfer -> pready_o=0, prdata_o=0, PRESCALER=PRESCALER_RST, no tx_wr_en_o/rx_rd_en_o.
- Write 0x5A to addr 0, then read addr 0, WAIT_STATES=0 -> prescaler_o=0x5A; read completes in first access cycle with prdata_o=0x5A, pslverr_o=0. Repeat with WAIT_STATES=2 -> pready_o rises 2 cycles later.
- TX push:
  - write 0x33 to addr 2 with tx_full_i=0 -> tx_data_o=0x33, single tx_wr_en_o pulse.
  - same write with tx_full_i=1 -> pslverr_o=1, no pulse.
- RX pop:
  - rx_empty_i=0, rx_data_i=0xC4 -> one rx_rd_en_o pulse, pready_o one cycle later, prdata_o=0xC4.
  - with rx_empty_i=1 -> pslverr_o=1, prdata_o=0, no pop.
- IRQ:
  - IRQ_EN=0x01, irq_src_i[0] pulse -> IRQ_STAT=0x01, irq_o=1.
  - W1C write 0x01 concurrent with a new irq_src_i[0] -> bit stays 1.
  - W1C alone -> irq_o=0 one cycle later.
- CMD: write CMD=0x03 -> cmd_o=0x03. cmd_clr_i pulse -> 0. cmd_clr_i coincident with a CMD=0x81 commit -> cmd_o=0x81. Write to addr 5 or unmapped addr 0x10 -> pslverr_o=1, no state change.

Source files
------------

// File: rtl/i2c_apb_regfile_v2.sv
// i2c_apb_regfile_v2: APB register block for the I2C core with wait states, PSLVERR,
// guarded TX/RX FIFO push/pop, self-clearing CMD and W1C interrupt status.
module i2c_apb_regfile_v2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int WAIT_STATES   = 0,
    parameter int PRESCALER_RST = 0
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [DATA_WIDTH-1:0] prescaler_o,
    output logic [DATA_WIDTH-1:0] cmd_o,
    output logic [DATA_WIDTH-1:0] address_rw_o,
    input  logic                  cmd_clr_i,
    input  logic [DATA_WIDTH-1:0] status_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_wr_en_o,
    input  logic                  tx_full_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  rx_rd_en_o,
    input  logic                  rx_empty_i,
    input  logic [DATA_WIDTH-1:0] irq_src_i,
    output logic                  irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_POP, S_RESP} state_t;
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    state_t state, state_n;
    logic [2:0] addr_q, cnt, a;
    logic wr_q, err_q, err_n, start, pop_d, commit, rx_ok;
    logic [DATA_WIDTH-1:0] wdata_q, rx_q, irq_en, irq_stat, rdata;
    always_comb begin
        a      = paddr_i[2:0];
        start  = psel_i && !penable_i;
        err_n  = ((paddr_i >> 3) != '0) ||
                 (pwrite_i && (a == 3'd3 || a == 3'd5)) ||
                 (pwrite_i && a == 3'd2 && tx_full_i) ||
                 (!pwrite_i && a == 3'd3 && rx_empty_i);
        rx_ok  = !pwrite_i && a == 3'd3 && !err_n;
        commit = state == S_RESP && psel_i && !err_q && wr_q;
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = rx_ok ? S_POP : (WS == 3'd0 ? S_RESP : S_WAIT);
            S_POP:  state_n = !psel_i ? S_IDLE : (cnt == 3'd0 ? S_RESP : S_WAIT);
            S_WAIT: state_n = !psel_i ? S_IDLE : (cnt == 3'd1 ? S_RESP : S_WAIT);
            default: state_n = S_IDLE;
        endcase
    end
    always_comb begin
        rdata = '0;
        case (addr_q)
            3'd0: rdata = prescaler_o;
            3'd1: rdata = cmd_o;
            3'd2: rdata = tx_data_o;
            3'd3: rdata = pop_d ? rx_data_i : rx_q;
            3'd4: rdata = address_rw_o;
            3'd5: rdata = status_i;
            3'd6: rdata = irq_en;
            default: rdata = irq_stat;
        endcase
    end
    assign pready_o   = state == S_RESP;
    assign pslverr_o  = pready_o && err_q;
    assign prdata_o   = (pready_o && !wr_q && !err_q) ? rdata : '0;
    assign rx_rd_en_o = state == S_POP;
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            cnt          <= '0;
            pop_d        <= 1'b0;
            rx_q         <= '0;
            prescaler_o  <= DATA_WIDTH'(PRESCALER_RST);
            cmd_o        <= '0;
            address_rw_o <= '0;
            tx_data_o    <= '0;
            tx_wr_en_o   <= 1'b0;
            irq_en       <= '0;
            irq_stat     <= '0;
            irq_o        <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                addr_q  <= a;
                wr_q    <= pwrite_i;
                err_q   <= err_n;
                wdata_q <= pwdata_i;
                cnt     <= WS;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 3'd1;
            end
            pop_d <= rx_rd_en_o;
            if (pop_d) rx_q <= rx_data_i;
            if (commit && addr_q == 3'd0) prescaler_o <= wdata_q;
            if (commit && addr_q == 3'd4) address_rw_o <= wdata_q;
            if (commit && addr_q == 3'd6) irq_en <= wdata_q;
            if (commit && addr_q == 3'd2) tx_data_o <= wdata_q;
            tx_wr_en_o <= commit && addr_q == 3'd2;
            cmd_o <= (commit && addr_q == 3'd1) ? wdata_q : (cmd_clr_i ? '0 : cmd_o);
            // new events are OR-ed in after the clear so a coincident set survives
            irq_stat <= (irq_stat & ~((commit && addr_q == 3'd7) ? wdata_q : '0)) | irq_src_i;
            irq_o <= |(irq_stat & irq_en);
        end
    end
endmodule

// File: tb/tb_i2c_apb_regfile_v2.sv
// tb_i2c_apb_regfile_v2: directed APB transfers with a response scoreboard and
// side-band checks of FIFO strobes, CMD and interrupt behaviour.
module tb_i2c_apb_regfile_v2;
    logic pclk = 1'b0, preset = 1'b1;
    logic psel = 1'b0, psel2 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic cmd_clr = 1'b0, tx_full = 1'b0, rx_empty = 1'b1;
    logic [7:0] status = '0, rx_data = '0, irq_src = '0;
    logic [7:0] prdata, prescaler, cmd, address_rw, tx_data;
    logic pready, pslverr, tx_wr_en, rx_rd_en, irq;
    logic [7:0] prdata2, prescaler2, cmd2, address_rw2, tx_data2;
    logic pready2, pslverr2, tx_wr_en2, rx_rd_en2, irq2;
    int n_vec = 0, n_err = 0, tx_cnt = 0, rx_cnt = 0, resp_idx = 0;
    typedef struct {bit rd; logic [7:0] d; bit e;} exp_t;
    exp_t sb[$];
    exp_t m;

    always #5 pclk = ~pclk;

    i2c_apb_regfile_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0), .PRESCALER_RST(8'h11)) dut (
        .pclk_i(pclk), .preset_i(preset), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
        .prescaler_o(prescaler), .cmd_o(cmd), .address_rw_o(address_rw), .cmd_clr_i(cmd_clr),
        .status_i(status), .tx_data_o(tx_data), .tx_wr_en_o(tx_wr_en), .tx_full_i(tx_full),
        .rx_data_i(rx_data), .rx_rd_en_o(rx_rd_en), .rx_empty_i(rx_empty), .irq_src_i(irq_src), .irq_o(irq));

    i2c_apb_regfile_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(2), .PRESCALER_RST(0)) dut_w2 (
        .pclk_i(pclk), .preset_i(preset), .psel_i(psel2), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata2), .pready_o(pready2), .pslverr_o(pslverr2),
        .prescaler_o(prescaler2), .cmd_o(cmd2), .address_rw_o(address_rw2), .cmd_clr_i(cmd_clr),
        .status_i(status), .tx_data_o(tx_data2), .tx_wr_en_o(tx_wr_en2), .tx_full_i(tx_full),
        .rx_data_i(rx_data), .rx_rd_en_o(rx_rd_en2), .rx_empty_i(rx_empty), .irq_src_i(irq_src), .irq_o(irq2));

    always @(posedge pclk) begin
        tx_cnt <= tx_cnt + int'(tx_wr_en);
        rx_cnt <= rx_cnt + int'(rx_rd_en);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (pready || pready2) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pready: got 1, expected 0");
            end else begin
                m = sb.pop_front();
                check($sformatf("resp%0d_pslverr", resp_idx), pready ? pslverr : pslverr2, m.e);
                if (m.rd) check($sformatf("resp%0d_prdata", resp_idx), pready ? prdata : prdata2, m.d);
                resp_idx++;
            end
        end
    end

    task automatic apb(input bit w2, input logic [7:0] a, input bit wr, input logic [7:0] wd,
                       input logic [7:0] ed, input bit ee, input int lat);
        int c;
        bit rdy;
        exp_t x;
        x.rd = !wr;
        x.d  = ed;
        x.e  = ee;
        sb.push_back(x);
        @(posedge pclk);
        #1;
        if (w2) psel2 = 1'b1; else psel = 1'b1;
        paddr = a;
        pwrite = wr;
        pwdata = wd;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        c = 0;
        do begin
            @(negedge pclk);
            rdy = w2 ? pready2 : pready;
            if (!rdy) c++;
        end while (!rdy && c < 20);
        check($sformatf("latency_a%0h_w%0d", a, wr), c, lat);
        @(posedge pclk);
        #1;
        psel = 1'b0;
        psel2 = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, r0;
        #12;
        check("rst_pready", pready, 0);
        check("rst_prdata", prdata, 0);
        check("rst_prescaler", prescaler, 8'h11);
        check("rst_cmd", cmd, 0);
        check("rst_irq", irq, 0);
        @(posedge pclk);
        #1 preset = 1'b0;
        // reset hits a TXDATA write in its access cycle: nothing may commit
        @(posedge pclk);
        #1;
        psel = 1'b1; paddr = 8'h02; pwrite = 1'b1; pwdata = 8'h77;
        @(posedge pclk);
        #1 penable = 1'b1;
        preset = 1'b1;
        #1;
        check("midrst_pready", pready, 0);
        check("midrst_prdata", prdata, 0);
        check("midrst_prescaler", prescaler, 8'h11);
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        check("midrst_tx_pulses", tx_cnt, 0);
        check("midrst_rx_pulses", rx_cnt, 0);
        check("midrst_tx_data", tx_data, 0);

        apb(0, 8'h00, 1, 8'h5A, 8'h00, 0, 0);
        check("prescaler_wr", prescaler, 8'h5A);
        apb(0, 8'h00, 0, 8'h00, 8'h5A, 0, 0);
        apb(1, 8'h00, 1, 8'h5A, 8'h00, 0, 2);
        check("w2_prescaler_wr", prescaler2, 8'h5A);
        apb(1, 8'h00, 0, 8'h00, 8'h5A, 0, 2);

        tx_full = 1'b0;
        t0 = tx_cnt;
        apb(0, 8'h02, 1, 8'h33, 8'h00, 0, 0);
        check("tx_wr_en_pulse", tx_wr_en, 1);
        check("tx_data", tx_data, 8'h33);
        @(posedge pclk);
        #1;
        check("tx_wr_en_drop", tx_wr_en, 0);
        check("tx_pulse_count", tx_cnt - t0, 1);
        apb(0, 8'h02, 0, 8'h00, 8'h33, 0, 0);
        tx_full = 1'b1;
        t0 = tx_cnt;
        apb(0, 8'h02, 1, 8'h44, 8'h00, 1, 0);
        repeat (2) @(posedge pclk);
        #1;
        check("txfull_no_pulse", tx_cnt - t0, 0);
        check("txfull_data_kept", tx_data, 8'h33);
        tx_full = 1'b0;

        rx_empty = 1'b0; rx_data = 8'hC4;
        r0 = rx_cnt;
        apb(0, 8'h03, 0, 8'h00, 8'hC4, 0, 1);
        check("rx_pop_count", rx_cnt - r0, 1);
        rx_empty = 1'b1;
        r0 = rx_cnt;
        apb(0, 8'h03, 0, 8'h00, 8'h00, 1, 0);
        check("rx_empty_no_pop", rx_cnt - r0, 0);

        apb(0, 8'h06, 1, 8'h01, 8'h00, 0, 0);
        @(posedge pclk);
        #1 irq_src = 8'h01;
        @(posedge pclk);
        #1 irq_src = 8'h00;
        check("irq_latency", irq, 0);
        @(posedge pclk);
        #1;
        check("irq_set", irq, 1);
        apb(0, 8'h07, 0, 8'h00, 8'h01, 0, 0);
        irq_src = 8'h01;
        apb(0, 8'h07, 1, 8'h01, 8'h00, 0, 0);
        irq_src = 8'h00;
        apb(0, 8'h07, 0, 8'h00, 8'h01, 0, 0);
        check("irq_set_wins", irq, 1);
        apb(0, 8'h07, 1, 8'h01, 8'h00, 0, 0);
        check("irq_w1c_lag", irq, 1);
        @(posedge pclk);
        #1;
        check("irq_w1c_clear", irq, 0);
        apb(0, 8'h07, 0, 8'h00, 8'h00, 0, 0);
        @(posedge pclk);
        #1 irq_src = 8'h02;
        @(posedge pclk);
        #1 irq_src = 8'h00;
        repeat (2) @(posedge pclk);
        #1;
        check("irq_masked", irq, 0);
        apb(0, 8'h07, 0, 8'h00, 8'h02, 0, 0);

        apb(0, 8'h01, 1, 8'h03, 8'h00, 0, 0);
        check("cmd_wr", cmd, 8'h03);
        @(posedge pclk);
        #1 cmd_clr = 1'b1;
        @(posedge pclk);
        #1 cmd_clr = 1'b0;
        check("cmd_clr", cmd, 8'h00);
        cmd_clr = 1'b1;
        apb(0, 8'h01, 1, 8'h81, 8'h00, 0, 0);
        cmd_clr = 1'b0;
        check("cmd_write_wins", cmd, 8'h81);

        status = 8'hA5;
        apb(0, 8'h05, 1, 8'hFF, 8'h00, 1, 0);
        apb(0, 8'h05, 0, 8'h00, 8'hA5, 0, 0);
        apb(0, 8'h10, 1, 8'h12, 8'h00, 1, 0);
        check("unmapped_no_change", prescaler, 8'h5A);
        apb(0, 8'h10, 0, 8'h00, 8'h00, 1, 0);
        apb(0, 8'h03, 1, 8'h66, 8'h00, 1, 0);
        apb(0, 8'h04, 1, 8'h9C, 8'h00, 0, 0);
        check("address_rw_wr", address_rw, 8'h9C);
        apb(0, 8'h04, 0, 8'h00, 8'h9C, 0, 0);
        apb(0, 8'h01, 0, 8'h00, 8'h81, 0, 0);

        repeat (3) @(posedge pclk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
